box_input_conditioner: RTL

BOX_INPUT_CONDITIONER -- requirements
Module: box_input_conditioner

---
 rtl/box_input_conditioner.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/box_input_conditioner.sv
// box_input_conditioner
// Cleans up the raw pad, start and super contacts for the game controller.
// Each contact goes through a two-flop synchroniser and a per-input debouncer.
// The debounced values then drive:
//   - the gated box occupancy,
//   - a one-cycle start pulse,
//   - a super-mode window that spends one of a limited number of charges.
// The super output is named super_active because `super` is a reserved word
// in SystemVerilog.
module box_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SUPER_CYCLES    = 8,
  parameter int SUPER_CHARGES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] pad_raw,
  input  logic       start_raw,
  input  logic       super_raw,
  input  logic [1:0] game_state,
  output logic [8:0] box,
  output logic       start,
  output logic       super_active,
  output logic [1:0] super_left
);

  // state  | meaning
  // IDLE   | no window running; waiting for a qualified super press
  // ACTIVE | invulnerability window running; win_cnt counts down to 0
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  localparam int         N_IN     = 11;
  localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] WIN_LAST = 8'(SUPER_CYCLES - 1);
  localparam logic [1:0] CHARGES  = 2'(SUPER_CHARGES);
  localparam logic [1:0] GS_INIT  = 2'b00;
  localparam logic [1:0] GS_PLAY  = 2'b01;

  // Bit layout of the bundled inputs: [8:0] pad, [9] start, [10] super.
  logic [N_IN-1:0]      raw_all;
  logic [N_IN-1:0]      sync_a;
  logic [N_IN-1:0]      sync_b;
  logic [N_IN-1:0]      db;
  logic [N_IN-1:0]      db_prev;
  logic [N_IN-1:0][7:0] cnt;

  logic [0:0] state;
  logic [7:0] win_cnt;
  logic       play;
  logic       start_rise;
  logic       super_rise;

  assign raw_all = {super_raw, start_raw, pad_raw};

  // Two-flop synchroniser for every raw contact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw_all;
      sync_b <= sync_a;
    end
  end

  // Per-input debounce.
  // A new level is accepted only after it has differed from the current
  // debounced level for DEBOUNCE_CYCLES consecutive synced cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db  <= '0;
      cnt <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (sync_b[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          db[i]  <= sync_b[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  // Previous debounced levels, used for edge detection of start and super.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_prev <= '0;
    end else begin
      db_prev <= db;
    end
  end

  assign play       = (game_state == GS_PLAY);
  assign start_rise = db[9] & ~db_prev[9];
  assign super_rise = db[10] & ~db_prev[10];

  // Super window FSM with its countdown and charge bookkeeping.
  // The INIT reload is written last so that it takes precedence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      win_cnt    <= '0;
      super_left <= CHARGES;
    end else begin
      case (state)
        ST_IDLE: begin
          if (super_rise && play && (super_left != 2'd0)) begin
            state      <= ST_ACTIVE;
            win_cnt    <= WIN_LAST;
            super_left <= super_left - 2'd1;
          end
        end
        ST_ACTIVE: begin
          if (!play || (win_cnt == 8'd0)) begin
            state   <= ST_IDLE;
            win_cnt <= '0;
          end else begin
            win_cnt <= win_cnt - 8'd1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          win_cnt <= '0;
        end
      endcase
      if (game_state == GS_INIT) begin
        super_left <= CHARGES;
      end
    end
  end

  // Output decode.
  // Box occupancy is only visible to the controller during PLAY.
  always_comb begin
    box          = play ? db[8:0] : 9'b0;
    start        = start_rise;
    super_active = (state == ST_ACTIVE);
  end

endmodule
